uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
// 100 MHz core clock at 115200 baud gives the default clocks-per-bit.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, reset to RST_VAL.
// Latency 2 clk cycles, no backpressure.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; rx_done/frame_err pulse one cycle after the stop sample.
// Start edge to rx_done is ~9.5 bit-times plus synchronizer delay; no backpressure, outputs are fire-and-forget.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID = CW'((CLKS_PER_BIT - 1) / 2);

    logic rx_s;

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          hold_off_q, hold_off_d;
    logic [1:0]    sync_warm_q, sync_warm_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // hold_off blocks new starts until the line is seen high; after reset the
    // synchronizer's preset 1s are not trusted until sync_warm has filled.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        done_d      = 1'b0;
        ferr_d      = 1'b0;
        hold_off_d  = hold_off_q;
        sync_warm_d = {sync_warm_q[0], 1'b1};

        if (hold_off_q && rx_s && sync_warm_q[1]) begin
            hold_off_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s && !hold_off_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        idx_d   = 3'd0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d     = 1'b1;
                        hold_off_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
            hold_off_q  <= 1'b1;
            sync_warm_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
            busy_q      <= busy_d;
            hold_off_q  <= hold_off_d;
            sync_warm_q <= sync_warm_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule
